// File: rtl/mux_scan_pkg.sv
// Shared types for the N-channel scan selector: FSM state encoding and mode values.
package mux_scan_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SAMPLE,
    HOLD,
    DWELL
  } state_e;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/mux_nx1.sv
// Combinational N_CH:1 selector of W-bit channels; zero data plus oob flag for idx >= N_CH.
// Latency 0; no flow control.
module mux_nx1 #(
  parameter int N_CH = 16,
  parameter int W    = 1
) (
  input  logic [N_CH*W-1:0]       din,
  input  logic [$clog2(N_CH)-1:0] idx,
  output logic [W-1:0]            y,
  output logic                    oob
);

  localparam int SELW = $clog2(N_CH);

  always_comb begin
    y = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (idx == SELW'(k)) y = din[k*W +: W];
    end
  end

  // Extra MSB keeps the compare exact when N_CH is a power of two.
  assign oob = ({1'b0, idx} >= (SELW + 1)'(N_CH));

endmodule

// File: rtl/mux_scan_sel.sv
// Channel selector, manual single sample or auto-scan sweep; optional out_par via MUX_SCAN_PARITY_EN.
// Latency: start accepted at t gives out_valid at t+2; beats spaced >= 2+DWELL cycles.
// Backpressure: sample is held in HOLD until out_ready; nothing is dropped or overwritten.
module mux_scan_sel #(
  parameter int N_CH  = 16,
  parameter int W     = 1,
  parameter int DWELL = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_CH*W-1:0]       din,
  input  logic [$clog2(N_CH)-1:0] sel,
  input  logic                    mode,
  input  logic                    start,
  output logic [W-1:0]            out_data,
  output logic [$clog2(N_CH)-1:0] out_ch,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    sel_err
`ifdef MUX_SCAN_PARITY_EN
  ,
  output logic                    out_par
`endif
);

  import mux_scan_pkg::*;

  localparam int SELW = $clog2(N_CH);
  localparam int CW   = (DWELL > 1) ? $clog2(DWELL) : 1;

  state_e          state;
  logic            mode_q;
  logic [SELW-1:0] idx;
  logic [CW-1:0]   dwell_cnt;
  logic [W-1:0]    mux_y;
  logic            mux_oob;

  mux_nx1 #(
    .N_CH (N_CH),
    .W    (W)
  ) u_mux (
    .din  (din),
    .idx  (idx),
    .y    (mux_y),
    .oob  (mux_oob)
  );

  assign busy = (state != IDLE);

  // The DWELL parameter shadows the enum literal, so the state is package-qualified.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mode_q    <= MODE_MANUAL;
      idx       <= '0;
      dwell_cnt <= '0;
      out_data  <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      sel_err   <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
      out_par   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mode_q    <= mode;
            idx       <= (mode == MODE_SCAN) ? '0 : sel;
            dwell_cnt <= '0;
            sel_err   <= 1'b0;
            state     <= SAMPLE;
          end
        end
        SAMPLE: begin
          out_data  <= mux_y;
          out_ch    <= idx;
          out_valid <= 1'b1;
`ifdef MUX_SCAN_PARITY_EN
          out_par   <= ^mux_y;
`endif
          if (mode_q == MODE_MANUAL && mux_oob) sel_err <= 1'b1;
          state <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (mode_q == MODE_MANUAL || idx == SELW'(N_CH - 1)) begin
              state <= IDLE;
            end else begin
              idx   <= idx + 1'b1;
              state <= (DWELL == 0) ? SAMPLE : mux_scan_pkg::DWELL;
            end
          end
        end
        mux_scan_pkg::DWELL: begin
          if (dwell_cnt == CW'(DWELL - 1)) begin
            dwell_cnt <= '0;
            state     <= SAMPLE;
          end else begin
            dwell_cnt <= dwell_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_sel.sv
// Directed bench: dut_a (16 ch x 8 bit, dwell 4) and dut_b (12 ch x 4 bit, dwell 0).
module tb_mux_scan_sel;

  localparam int NA = 16, WA = 8, DA = 4, SA = $clog2(NA);
  localparam int NB = 12, WB = 4, DB = 0, SB = $clog2(NB);

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [NA*WA-1:0] a_din;
  logic [SA-1:0]    a_sel, a_ch;
  logic             a_mode, a_start, a_ready, a_valid, a_busy, a_err;
  logic [WA-1:0]    a_data;

  logic [NB*WB-1:0] b_din;
  logic [SB-1:0]    b_sel, b_ch;
  logic             b_mode, b_start, b_ready, b_valid, b_busy, b_err;
  logic [WB-1:0]    b_data;
`ifdef MUX_SCAN_PARITY_EN
  logic a_par, b_par;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mux_scan_sel #(.N_CH(NA), .W(WA), .DWELL(DA)) dut_a (
    .clk(clk), .rst_n(rst_n), .din(a_din), .sel(a_sel), .mode(a_mode), .start(a_start),
    .out_data(a_data), .out_ch(a_ch), .out_valid(a_valid), .out_ready(a_ready),
    .busy(a_busy), .sel_err(a_err)
`ifdef MUX_SCAN_PARITY_EN
    , .out_par(a_par)
`endif
  );

  mux_scan_sel #(.N_CH(NB), .W(WB), .DWELL(DB)) dut_b (
    .clk(clk), .rst_n(rst_n), .din(b_din), .sel(b_sel), .mode(b_mode), .start(b_start),
    .out_data(b_data), .out_ch(b_ch), .out_valid(b_valid), .out_ready(b_ready),
    .busy(b_busy), .sel_err(b_err)
`ifdef MUX_SCAN_PARITY_EN
    , .out_par(b_par)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_a(input string tag, output int at);
    int n = 0;
    while (a_valid !== 1'b1 && n < 40) begin tick(); n++; end
    at = cyc;
    check(tag, a_valid, 1'b1);
  endtask

  task automatic wait_b(input string tag, output int at);
    int n = 0;
    while (b_valid !== 1'b1 && n < 40) begin tick(); n++; end
    at = cyc;
    check(tag, b_valid, 1'b1);
  endtask

  function automatic logic [NA*WA-1:0] ramp_a();
    logic [NA*WA-1:0] v;
    for (int k = 0; k < NA; k++) v[k*WA +: WA] = WA'(k);
    return v;
  endfunction

  function automatic logic [NB*WB-1:0] ramp_b();
    logic [NB*WB-1:0] v;
    for (int k = 0; k < NB; k++) v[k*WB +: WB] = WB'(k + 1);
    return v;
  endfunction

  initial begin
    int t, prev;
    a_din = ramp_a(); a_sel = '0; a_mode = 1'b0; a_start = 1'b0; a_ready = 1'b1;
    b_din = ramp_b(); b_sel = '0; b_mode = 1'b0; b_start = 1'b0; b_ready = 1'b1;
    prev = 0;

    // Reset values
    #12;
    check("rst_valid", a_valid, 1'b0);
    check("rst_busy", a_busy, 1'b0);
    check("rst_ch", a_ch, 4'd0);
    check("rst_data", a_data, 8'd0);
    check("rst_err", a_err, 1'b0);
    tick(); rst_n = 1'b1; tick();

    // Manual sample of channel 15; sel/mode changes after acceptance must not matter
    a_din[15*WA +: WA] = 8'hA7;
    a_sel = 4'd15; a_mode = 1'b0; a_start = 1'b1;
    tick();
    a_start = 1'b0; a_sel = 4'd3; a_mode = 1'b1;
    check("man_busy", a_busy, 1'b1);
    check("man_lat1", a_valid, 1'b0);
    tick();
    check("man_valid", a_valid, 1'b1);
    check("man_data", a_data, 8'hA7);
    check("man_ch", a_ch, 4'd15);
`ifdef MUX_SCAN_PARITY_EN
    check("man_par_a7", a_par, 1'b1);
`endif
    tick();
    check("man_done_valid", a_valid, 1'b0);
    check("man_done_busy", a_busy, 1'b0);

    // Second manual pattern: channel 2 = 8'hFF
    a_din[2*WA +: WA] = 8'hFF;
    a_sel = 4'd2; a_mode = 1'b0; a_start = 1'b1;
    tick(); a_start = 1'b0; tick();
    check("man2_data", a_data, 8'hFF);
    check("man2_ch", a_ch, 4'd2);
`ifdef MUX_SCAN_PARITY_EN
    check("man2_par_ff", a_par, 1'b0);
`endif
    tick();
    check("man2_busy", a_busy, 1'b0);
    a_din = ramp_a();

    // Full sweep with 10-cycle backpressure on beat 3
    a_mode = 1'b1; a_start = 1'b1;
    tick(); a_start = 1'b0;
    for (int b = 0; b < NA; b++) begin
      wait_a($sformatf("scan_vld%0d", b), t);
      check($sformatf("scan_ch%0d", b), a_ch, 64'(b));
      check($sformatf("scan_data%0d", b), a_data, 64'(b));
      if (b > 0 && b != 4) check($sformatf("scan_gap%0d", b), 64'(t - prev), 64'(2 + DA));
      prev = t;
      if (b == 3) begin
        a_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
          a_din = ~a_din;
          tick();
          check($sformatf("hold%0d", i), {a_valid, a_ch, a_data}, {1'b1, 4'd3, 8'd3});
        end
        a_din = ramp_a();
        a_ready = 1'b1;
      end
      tick();
      if (b == NA - 1) begin
        check("scan_end_busy", a_busy, 1'b0);
        check("scan_end_valid", a_valid, 1'b0);
      end
    end

    // Out-of-range manual select on the 12-channel instance
    b_sel = 4'd13; b_mode = 1'b0; b_start = 1'b1;
    tick(); b_start = 1'b0; tick();
    check("oob_valid", b_valid, 1'b1);
    check("oob_data", b_data, 4'd0);
    check("oob_ch", b_ch, 4'd13);
    check("oob_err", b_err, 1'b1);
    tick();
    check("oob_err_sticky", b_err, 1'b1);
    check("oob_busy", b_busy, 1'b0);
    b_sel = 4'd2; b_start = 1'b1;
    tick(); b_start = 1'b0;
    check("oob_err_clr", b_err, 1'b0);
    tick();
    check("inb_data", b_data, 4'd3);
    check("inb_ch", b_ch, 4'd2);
    tick();

    // Zero-dwell sweep over a non-power-of-two channel count
    b_mode = 1'b1; b_start = 1'b1;
    tick(); b_start = 1'b0;
    for (int b = 0; b < NB; b++) begin
      wait_b($sformatf("bscan_vld%0d", b), t);
      check($sformatf("bscan_ch%0d", b), b_ch, 64'(b));
      check($sformatf("bscan_data%0d", b), b_data, 64'(b + 1));
      if (b > 0) check($sformatf("bscan_gap%0d", b), 64'(t - prev), 64'(2));
      prev = t;
      tick();
    end
    check("bscan_end_busy", b_busy, 1'b0);
    tick(); tick();
    check("bscan_no_extra", b_valid, 1'b0);

    // Start while busy is ignored; async reset mid-sweep at beat 5
    a_mode = 1'b1; a_start = 1'b1;
    tick(); a_start = 1'b0;
    for (int b = 0; b < 6; b++) begin
      wait_a($sformatf("rs_vld%0d", b), t);
      check($sformatf("rs_ch%0d", b), a_ch, 64'(b));
      if (b == 1) begin a_start = 1'b1; a_mode = 1'b0; a_sel = 4'd9; end
      if (b == 5) begin
        #1 rst_n = 1'b0;
        #1;
        check("arst_valid", a_valid, 1'b0);
        check("arst_busy", a_busy, 1'b0);
        check("arst_ch", a_ch, 4'd0);
        check("arst_data", a_data, 8'd0);
      end else begin
        tick();
        a_start = 1'b0;
      end
    end
    tick(); tick(); rst_n = 1'b1; tick();
    check("post_rst_busy", a_busy, 1'b0);
    a_mode = 1'b1; a_start = 1'b1;
    tick(); a_start = 1'b0;
    wait_a("re_vld0", t);
    check("re_ch0", a_ch, 4'd0);
    check("re_data0", a_data, 8'd0);
    tick();
    wait_a("re_vld1", t);
    check("re_ch1", a_ch, 4'd1);
    check("re_data1", a_data, 8'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
